// File: rtl/stepper_seq.sv
// Stepper-motor phase sequencer: full/half-step coil patterns, programmable step rate and move length.
// Optional IDLE_RELEASE_EN: de-energise the coils when a move finishes (phase is kept).
module stepper_seq #(
  parameter int PHASES = 4,
  parameter int CNT_W  = 16,
  parameter int DIV_W  = 16,
  parameter int PH_W   = $clog2(2 * PHASES)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [CNT_W-1:0]  steps,
  input  logic              dir,
  input  logic              half,
  input  logic [DIV_W-1:0]  div,
  input  logic              abort,
  output logic [PHASES-1:0] coils,
  output logic [PH_W-1:0]   phase,
  output logic [CNT_W-1:0]  remaining,
  output logic              busy,
  output logic              done
);

  localparam int NPH = 2 * PHASES;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state_reg;
  logic             dir_reg;
  logic             half_reg;
  logic [DIV_W-1:0] div_reg;
  logic [DIV_W-1:0] prescaler_reg;

  // Constant coil pattern per phase index: even k drives one coil, odd k drives
  // that coil plus the next lower one (wrapping from bit 0 to the top bit).
  logic [PHASES-1:0] pat_tbl [NPH];
  localparam logic [PHASES-1:0] ONE_HOT = {{(PHASES-1){1'b0}}, 1'b1};

  generate
    for (genvar gi = 0; gi < NPH; gi++) begin : g_pat
      localparam int HI = PHASES - 1 - gi / 2;
      localparam int LO = (HI == 0) ? PHASES - 1 : HI - 1;
      if (gi % 2 == 0) begin : g_even
        assign pat_tbl[gi] = ONE_HOT << HI;
      end else begin : g_odd
        assign pat_tbl[gi] = (ONE_HOT << HI) | (ONE_HOT << LO);
      end
    end
  endgenerate

  // Next phase for the latched mode. Full-step from an even index takes a single
  // alignment step onto the two-coil pattern; afterwards it moves two at a time.
  logic [PH_W:0]   step_amt;
  logic [PH_W:0]   phase_sum;
  logic [PH_W-1:0] phase_next;

  always_comb begin
    step_amt  = (half_reg || !phase[0]) ? (PH_W+1)'(1) : (PH_W+1)'(2);
    phase_sum = '0;
    if (!dir_reg) begin
      phase_sum = {1'b0, phase} + step_amt;
    end else begin
      phase_sum = {1'b0, phase} + (PH_W+1)'(NPH) - step_amt;
    end
    if (phase_sum >= (PH_W+1)'(NPH)) begin
      phase_sum = phase_sum - (PH_W+1)'(NPH);
    end
    phase_next = phase_sum[PH_W-1:0];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg     <= S_IDLE;
      dir_reg       <= 1'b0;
      half_reg      <= 1'b0;
      div_reg       <= '0;
      prescaler_reg <= '0;
      coils         <= '0;
      phase         <= '0;
      remaining     <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            if (steps != '0) begin
              dir_reg       <= dir;
              half_reg      <= half;
              div_reg       <= div;
              prescaler_reg <= div;
              remaining     <= steps;
              coils         <= pat_tbl[phase];
              busy          <= 1'b1;
              state_reg     <= S_RUN;
            end else begin
              done      <= 1'b1;
              state_reg <= S_DONE;
            end
          end
        end

        S_RUN: begin
          // Abort beats a step that would otherwise land on this same edge.
          if (abort) begin
            busy      <= 1'b0;
            done      <= 1'b1;
            state_reg <= S_DONE;
          end else if (prescaler_reg == '0) begin
            phase         <= phase_next;
            coils         <= pat_tbl[phase_next];
            remaining     <= remaining - 1'b1;
            prescaler_reg <= div_reg;
            if (remaining == CNT_W'(1)) begin
              busy      <= 1'b0;
              done      <= 1'b1;
              state_reg <= S_DONE;
            end
          end else begin
            prescaler_reg <= prescaler_reg - 1'b1;
          end
        end

        S_DONE: begin
          done      <= 1'b0;
          state_reg <= S_IDLE;
`ifdef IDLE_RELEASE_EN
          coils     <= '0;
`endif
        end

        default: begin
          busy      <= 1'b0;
          done      <= 1'b0;
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stepper_seq.sv
// Bench for stepper_seq: directed moves with literal expectations plus random traffic
// compared every cycle against a schedule-based model of the move engine.
module tb_stepper_seq;
  localparam int P   = 4;
  localparam int NPH = 2 * P;
  localparam int CW  = 16;
  localparam int DW  = 16;
  localparam int PW  = $clog2(NPH);

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [CW-1:0] steps = '0;
  logic          dir   = 1'b0;
  logic          half  = 1'b0;
  logic [DW-1:0] div   = '0;
  logic          abort = 1'b0;
  logic [P-1:0]  coils;
  logic [PW-1:0] phase;
  logic [CW-1:0] remaining;
  logic          busy;
  logic          done;

  int checks = 0;
  int errors = 0;
  bit checking = 1'b0;

  stepper_seq #(.PHASES(P), .CNT_W(CW), .DIV_W(DW)) dut (
    .clock(clock), .reset(reset), .start(start), .steps(steps), .dir(dir),
    .half(half), .div(div), .abort(abort), .coils(coils), .phase(phase),
    .remaining(remaining), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Coil pattern straight from the phase-index rule.
  function automatic logic [P-1:0] pat(int k);
    logic [P-1:0] v;
    int j;
    v = '0;
    j = P - 1 - k / 2;
    v[j] = 1'b1;
    if (k % 2 == 1) v[(j == 0) ? P - 1 : j - 1] = 1'b1;
    return v;
  endfunction

  function automatic int adv(int k, bit d, bit h);
    int amt;
    amt = (h || (k % 2 == 0)) ? 1 : 2;
    return d ? (k - amt + NPH) % NPH : (k + amt) % NPH;
  endfunction

  // Model: a move accepted at edge t0 steps on every edge t0 + n*(div+1).
  int           m_state;   // 0 idle, 1 moving, 2 finishing
  logic [P-1:0] m_coils;
  int           m_phase, m_rem, m_div;
  bit           m_dir, m_half, m_busy, m_done;
  longint       cyc, m_t0;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_state <= 0; m_coils <= '0; m_phase <= 0; m_rem <= 0;
      m_busy <= 1'b0; m_done <= 1'b0; cyc <= 0; m_t0 <= 0;
      m_div <= 0; m_dir <= 1'b0; m_half <= 1'b0;
    end else begin
      cyc <= cyc + 1;
      if (m_state == 0) begin
        m_done <= 1'b0;
        if (start && steps != 0) begin
          m_state <= 1; m_t0 <= cyc; m_rem <= int'(steps); m_div <= int'(div);
          m_dir <= dir; m_half <= half; m_coils <= pat(m_phase); m_busy <= 1'b1;
        end else if (start) begin
          m_state <= 2; m_done <= 1'b1;
        end
      end else if (m_state == 1) begin
        if (abort) begin
          m_state <= 2; m_busy <= 1'b0; m_done <= 1'b1;
        end else if (cyc != m_t0 && ((cyc - m_t0) % longint'(m_div + 1)) == 0) begin
          m_phase <= adv(m_phase, m_dir, m_half);
          m_coils <= pat(adv(m_phase, m_dir, m_half));
          m_rem   <= m_rem - 1;
          if (m_rem == 1) begin
            m_state <= 2; m_busy <= 1'b0; m_done <= 1'b1;
          end
        end
      end else begin
        m_state <= 0; m_done <= 1'b0;
`ifdef IDLE_RELEASE_EN
        m_coils <= '0;
`endif
      end
    end
  end

  always @(negedge clock) begin
    if (checking) begin
      check("model_coils", int'(coils), int'(m_coils));
      check("model_phase", int'(phase), m_phase);
      check("model_remaining", int'(remaining), m_rem);
      check("model_busy", int'(busy), int'(m_busy));
      check("model_done", int'(done), int'(m_done));
    end
  end

  task automatic launch(int n, bit d, bit h, int dv);
    start = 1'b1; steps = CW'(n); dir = d; half = h; div = DW'(dv);
    @(negedge clock);
    start = 1'b0;
  endtask

`ifdef IDLE_RELEASE_EN
  localparam bit RELEASE = 1'b1;
`else
  localparam bit RELEASE = 1'b0;
`endif

  initial begin
    logic [P-1:0] seq1 [8];
    logic [P-1:0] seq2 [3];
    logic [P-1:0] seq3 [3];
    int ph3 [3];
    int busy_cnt;
    seq1 = '{4'b1100, 4'b0100, 4'b0110, 4'b0010, 4'b0011, 4'b0001, 4'b1001, 4'b1000};
    seq2 = '{4'b1001, 4'b0001, 4'b0011};
    seq3 = '{4'b1100, 4'b0110, 4'b0011};
    ph3  = '{1, 3, 5};

    #1 reset = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    checking = 1'b1;
    check("rst_coils", int'(coils), 0);
    check("rst_phase", int'(phase), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_remaining", int'(remaining), 0);

    // Half-step forward, eight steps at full rate.
    launch(8, 1'b0, 1'b1, 0);
    check("t1_first_coils", int'(coils), 4'b1000);
    check("t1_busy", int'(busy), 1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      check("t1_seq", int'(coils), int'(seq1[i]));
    end
    check("t1_done", int'(done), 1);
    check("t1_busy_end", int'(busy), 0);
    check("t1_phase", int'(phase), 0);
    check("t1_remaining", int'(remaining), 0);
    @(negedge clock);
    check("t1_idle_coils", int'(coils), RELEASE ? 0 : 4'b1000);
    check("t1_done_pulse", int'(done), 0);

    // Half-step reverse.
    launch(3, 1'b1, 1'b1, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("t2_seq", int'(coils), int'(seq2[i]));
    end
    check("t2_phase", int'(phase), 5);
    @(negedge clock);

    // Async reset back to phase 0, then full-step forward.
    #2 reset = 1'b0;
    #1 check("t3_rst_phase", int'(phase), 0);
    @(negedge clock);
    reset = 1'b1;
    launch(3, 1'b0, 1'b0, 0);
    check("t3_first_coils", int'(coils), 4'b1000);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("t3_seq", int'(coils), int'(seq3[i]));
      check("t3_phase", int'(phase), ph3[i]);
    end
    @(negedge clock);

    // Divided rate with a stray start mid-move (phase 5 -> 6 -> 7).
    launch(2, 1'b0, 1'b1, 3);
    busy_cnt = 0;
    check("t4_rem0", int'(remaining), 2);
    for (int i = 1; i <= 8; i++) begin
      if (busy) busy_cnt++;
      start = (i == 2);
      @(negedge clock);
      check("t4_remaining", int'(remaining), (i < 4) ? 2 : (i < 8) ? 1 : 0);
    end
    start = 1'b0;
    check("t4_busy_cycles", busy_cnt, 8);
    check("t4_done", int'(done), 1);
    check("t4_phase", int'(phase), 7);
    @(negedge clock);

    // Abort after the second step (phase 7 -> 0 -> 1).
    launch(5, 1'b0, 1'b1, 0);
    repeat (2) @(negedge clock);
    check("t5_rem_pre", int'(remaining), 3);
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    check("t5_done", int'(done), 1);
    check("t5_remaining", int'(remaining), 3);
    check("t5_phase", int'(phase), 1);
    check("t5_coils", int'(coils), 4'b1100);
    @(negedge clock);

    // Zero-length move.
    launch(0, 1'b0, 1'b1, 0);
    check("t5_zero_done", int'(done), 1);
    check("t5_zero_busy", int'(busy), 0);
    check("t5_zero_coils", int'(coils), RELEASE ? 0 : 4'b1100);
    @(negedge clock);

    // Reset in the middle of a move.
    launch(10, 1'b0, 1'b1, 0);
    repeat (2) @(negedge clock);
    @(posedge clock);
    #2 reset = 1'b0;
    #1;
    check("t6_coils", int'(coils), 0);
    check("t6_phase", int'(phase), 0);
    check("t6_busy", int'(busy), 0);
    @(negedge clock);
    reset = 1'b1;

    // Random traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      start = ($urandom_range(0, 3) == 0);
      steps = CW'($urandom_range(0, 12));
      dir   = 1'($urandom_range(0, 1));
      half  = 1'($urandom_range(0, 1));
      div   = DW'($urandom_range(0, 3));
      abort = ($urandom_range(0, 40) == 0);
      if ($urandom_range(0, 500) == 0) begin
        #2 reset = 1'b0;
      end
      @(negedge clock);
      reset = 1'b1;
    end
    start = 1'b0;
    abort = 1'b0;
    repeat (3) @(negedge clock);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
